// File: rtl/ram_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg
//   Shared definitions for the small RAM building blocks (ram8_16, ram64_16,
//   CPU register bank).
//   Contents:
//     WIDTH    default data word width (16)
//     ADDR_W   default address width (3)
//     DEPTH    number of words, 2**ADDR_W
//     word_t   one data word
//     WORD_RST value every word takes while reset is asserted
// ----------------------------------------------------------------------------
package ram_pkg;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [WIDTH-1:0] word_t;

    localparam word_t WORD_RST = '0;

endpackage

// File: rtl/register16.sv
// ----------------------------------------------------------------------------
// register16
//   One storage word with a load enable and an asynchronous active-high
//   reset. The word captures d on a rising clk edge when load=1 and holds
//   otherwise.
//   Ports:
//     clk    in   1      rising-edge clock
//     reset  in   1      asynchronous, active-high; forces q to WORD_RST
//     load   in   1      capture enable, sampled at rising clk
//     d      in   WIDTH  data to capture
//     q      out  WIDTH  stored word
// ----------------------------------------------------------------------------
module register16
    import ram_pkg::*;
#(
    parameter int WIDTH = ram_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= WIDTH'(WORD_RST);
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ram8_16.sv
// ----------------------------------------------------------------------------
// ram8_16
//   8-word x 16-bit storage. A word is written on a rising clk edge and read
//   back combinationally at any time through the same address.
//   Ports:
//     clk      in   1       rising-edge clock
//     reset    in   1       asynchronous, active-high; clears every word
//     in       in   WIDTH   write data
//     load     in   1       write enable, sampled at rising clk
//     address  in   ADDR_W  word select for both write and read
//     out      out  WIDTH   read data
//   Build option:
//     RAM8_WRITE_BYPASS_EN  when defined, out follows in while load=1 and
//                           reset=0 (write-through). Otherwise out always
//                           shows the stored word (read-before-write).
//                           Stored contents and write timing do not change.
// ----------------------------------------------------------------------------
module ram8_16
    import ram_pkg::*;
#(
    parameter int WIDTH  = ram_pkg::WIDTH,
    parameter int ADDR_W = ram_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [WIDTH-1:0]  out
);

    localparam int NWORDS = 1 << ADDR_W;

    logic [NWORDS-1:0] word_load;
    logic [WIDTH-1:0]  words [NWORDS];
    logic [WIDTH-1:0]  rd_word;

    // Write decode (dmux8way): route load to the addressed word only.
    always_comb begin
        word_load          = '0;
        word_load[address] = load;
    end

    for (genvar i = 0; i < NWORDS; i++) begin : g_word
        register16 #(
            .WIDTH (WIDTH)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .load  (word_load[i]),
            .d     (in),
            .q     (words[i])
        );
    end

    // Read select (mux8way16): every address code selects a real word.
    assign rd_word = words[address];

`ifdef RAM8_WRITE_BYPASS_EN
    // Reset wins over bypass so out reads zero while reset is held.
    assign out = (load && !reset) ? in : rd_word;
`else
    assign out = rd_word;
`endif

endmodule
